octa_issue_ctrl: RTL

//  Decode/issue sequencer that drives the 8-bit ALU from the instruction side.

---
 rtl/octa_pkg.sv | 43 ++++
 rtl/octa_regfile.sv | 40 ++++
 rtl/octa_issue_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/octa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// octa_pkg : opcodes, FSM state type and instruction field slices. Rev 1.0
// ---------------------------------------------------------------------------
package octa_pkg;

  localparam int OCTA_DATA_W  = 8;
  localparam int OCTA_INSTR_W = 16;
  localparam int OCTA_NREGS   = 8;

  localparam logic [2:0] OP_ADDSUB  = 3'b000;
  localparam logic [2:0] OP_NANDNOR = 3'b001;
  localparam logic [2:0] OP_SLTU    = 3'b100;
  localparam logic [2:0] OP_SHIFT   = 3'b101;
  localparam logic [2:0] OP_SRA     = 3'b110;
  localparam logic [2:0] OP_LDI     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 13;
  localparam int FLAG_BIT = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 9;
  localparam int RS1_HI   = 8;
  localparam int RS1_LO   = 6;
  localparam int RS2_HI   = 5;
  localparam int RS2_LO   = 3;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  // Opcodes 010 and 011 are unassigned.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011);
  endfunction

endpackage
`default_nettype wire

// File: rtl/octa_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// octa_regfile : NREGS x DATA_W, two async read ports, debug port, r0 = 0. Rev 1.0
// ---------------------------------------------------------------------------
module octa_regfile
  import octa_pkg::*;
#(
  parameter int DATA_W = OCTA_DATA_W,
  parameter int NREGS  = OCTA_NREGS,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_rs1_addr,
  input  logic [AW-1:0]     i_rs2_addr,
  input  logic [AW-1:0]     i_dbg_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/octa_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// octa_issue_ctrl : 4-cycle decode/issue sequencer feeding the external 8-bit ALU.
// Option macro OCTA_OVF_STICKY_EN makes ovf_status sticky.            Rev 1.0
// ---------------------------------------------------------------------------
module octa_issue_ctrl
  import octa_pkg::*;
#(
  parameter int DATA_W  = OCTA_DATA_W,
  parameter int INSTR_W = OCTA_INSTR_W,
  parameter int NREGS   = OCTA_NREGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr,
  output logic [DATA_W-1:0]        alu_rs1,
  output logic [DATA_W-1:0]        alu_rs2,
  output logic [2:0]               alu_ctrl,
  output logic                     alu_flag,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_overflow,
  output logic                     done,
  output logic                     illegal,
  output logic                     ovf_status,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t              r_state;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_result;
  logic                r_ovf;

  logic [2:0]          w_op;
  logic [AW-1:0]       w_rd;
  logic [DATA_W-1:0]   w_rs1_data;
  logic [DATA_W-1:0]   w_rs2_data;
  logic                w_illegal;
  logic                w_is_ldi;
  logic                w_alu_op;
  logic                w_we;

  assign w_op      = r_instr[OP_HI:OP_LO];
  assign w_rd      = r_instr[RD_HI:RD_LO];
  assign w_illegal = op_is_illegal(w_op);
  assign w_is_ldi  = (w_op == OP_LDI);
  assign w_alu_op  = !w_illegal && !w_is_ldi;
  assign w_we      = (r_state == ST_WB) && !w_illegal;

  octa_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (r_instr[RS1_HI:RS1_LO]),
    .i_rs2_addr (r_instr[RS2_HI:RS2_LO]),
    .i_dbg_addr (dbg_addr),
    .i_wr_en    (w_we),
    .i_wr_addr  (w_rd),
    .i_wr_data  (r_result),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_instr     <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      instr_ready <= 1'b1;
      alu_rs1     <= '0;
      alu_rs2     <= '0;
      alu_ctrl    <= '0;
      alu_flag    <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      ovf_status  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            r_instr     <= instr;
            instr_ready <= 1'b0;
            r_state     <= ST_DEC;
          end
        end
        ST_DEC: begin
          // LDI and illegal ops leave the ALU bus at zero through EXEC.
          if (w_alu_op) begin
            alu_rs1  <= w_rs1_data;
            alu_rs2  <= w_rs2_data;
            alu_ctrl <= w_op;
            alu_flag <= r_instr[FLAG_BIT];
          end
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result <= w_is_ldi ? r_instr[IMM_HI:IMM_LO] : alu_out;
          r_ovf    <= (w_op == OP_ADDSUB) && alu_overflow;
          alu_rs1  <= '0;
          alu_rs2  <= '0;
          alu_ctrl <= '0;
          alu_flag <= 1'b0;
          done     <= 1'b1;
          illegal  <= w_illegal;
          r_state  <= ST_WB;
        end
        ST_WB: begin
          done        <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
          r_state     <= ST_IDLE;
`ifdef OCTA_OVF_STICKY_EN
          if (r_ovf) ovf_status <= 1'b1;
`else
          if (w_alu_op) ovf_status <= r_ovf;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
